// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART transmit scheduler
// Purpose: FSM state encoding, default byte width and byte-counter width.
// Ports: none (package).
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        CHECK = 2'd2
    } sched_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - producer/buffer side bundle of the UART transmit scheduler
// Purpose: groups requester inputs, buffer backpressure and scheduler outputs.
// Ports (signals):
//   arb_en, req[NUM_REQ], req_data[NUM_REQ*DATA_W], buf_full   -> scheduler
//   grant[NUM_REQ], wr_Sig, test_Data[DATA_W], owner[2], busy, sent_cnt[CNT_W] <- scheduler
// Modports: master = producers/buffer side, slave = scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = uart_sched_pkg::DATA_W_DEF
);
    logic                            arb_en;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*DATA_W-1:0]       req_data;
    logic                            buf_full;
    logic [NUM_REQ-1:0]              grant;
    logic                            wr_Sig;
    logic [DATA_W-1:0]               test_Data;
    logic [1:0]                      owner;
    logic                            busy;
    logic [uart_sched_pkg::CNT_W-1:0] sent_cnt;

    modport master (
        output arb_en, req, req_data, buf_full,
        input  grant, wr_Sig, test_Data, owner, busy, sent_cnt
    );

    modport slave (
        input  arb_en, req, req_data, buf_full,
        output grant, wr_Sig, test_Data, owner, busy, sent_cnt
    );
endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// rtl/uart_tx_sched_rr_pick.sv - combinational round-robin picker
// Purpose: finds the first set request bit at or after ptr, wrapping around.
// Ports:
//   req_i   [NUM_REQ] request levels
//   ptr_i   [2]       highest-priority index
//   found_o           at least one request set
//   idx_o   [2]       winning index
module rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic               found_o,
    output logic [1:0]         idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = 2'd0;
        // Pass 1: lowest index below ptr (the wrapped part).
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k] && (k < int'(ptr_i))) begin
                found_o = 1'b1;
                idx_o   = 2'(k);
            end
        end
        // Pass 2: lowest index at or above ptr overrides the wrapped choice.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k] && (k >= int'(ptr_i))) begin
                found_o = 1'b1;
                idx_o   = 2'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin burst scheduler for the UART transmit buffer write port
// Purpose: grants one producer a burst of up to BURST_LEN bytes, honours buf_full,
//          then rotates priority to the next index after the released owner.
// Ports:
//   sample_Clk  bit-rate sample clock
//   reset       asynchronous active-low reset
//   bus         uart_tx_sched_if.slave (arb_en, req, req_data, buf_full in;
//               grant, wr_Sig, test_Data, owner, busy, sent_cnt out)
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 8
) (
    input  logic             sample_Clk,
    input  logic             reset,
    uart_tx_sched_if.slave   bus
);

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    sched_state_e        state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    sent_q, sent_d;

    logic                pick_found;
    logic [1:0]          pick_idx;
    logic [1:0]          sel_idx;
    logic [DATA_W-1:0]   sel_data;
    logic                owner_req;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // In IDLE the candidate is the round-robin winner; mid-burst it is the owner.
    assign sel_idx = (state_q == IDLE) ? pick_idx : owner_q;

    always_comb begin
        sel_data  = '0;
        owner_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (2'(k) == sel_idx) sel_data  = bus.req_data[k*DATA_W +: DATA_W];
            if (2'(k) == owner_q) owner_req = bus.req[k];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        grant_d = '0;
        sent_d  = sent_q;
        case (state_q)
            IDLE: begin
                if (bus.arb_en && pick_found && !bus.buf_full) begin
                    owner_d = pick_idx;
                    wr_d    = 1'b1;
                    data_d  = sel_data;
                    grant_d = ONE << sel_idx;
                    cnt_d   = 8'd1;
                    sent_d  = sent_q + 1'b1;
                    state_d = ACK;
                end
            end
            // Requester is swapping to its next byte now; req is not trusted here.
            ACK: state_d = CHECK;
            CHECK: begin
                if (!bus.arb_en || !owner_req || (cnt_q == BURST_LEN_C)) begin
                    ptr_d   = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (!bus.buf_full) begin
                    wr_d    = 1'b1;
                    data_d  = sel_data;
                    grant_d = ONE << sel_idx;
                    cnt_d   = cnt_q + 8'd1;
                    sent_d  = sent_q + 1'b1;
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= 8'd0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            sent_q  <= sent_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.wr_Sig    = wr_q;
    assign bus.test_Data = data_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sent_cnt  = sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NR = 3;
    localparam int DW = 8;

    logic sample_Clk = 1'b0;
    logic reset      = 1'b0;
    always #5 sample_Clk = ~sample_Clk;

    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) b8 ();
    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) b1 ();

    uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(8)) dut8 (
        .sample_Clk (sample_Clk),
        .reset      (reset),
        .bus        (b8)
    );

    uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(1)) dut1 (
        .sample_Clk (sample_Clk),
        .reset      (reset),
        .bus        (b1)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         cyc;

    typedef struct {
        logic       en;
        logic [2:0] req;
        logic       bf;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [2:0] exp_grant;
        logic [1:0] exp_owner;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic upd8();
        b8.req[0] = (q0.size() > 0);
        b8.req[1] = (q1.size() > 0);
        b8.req[2] = (q2.size() > 0);
        b8.req_data[7:0]   = (q0.size() > 0) ? q0[0] : 8'h00;
        b8.req_data[15:8]  = (q1.size() > 0) ? q1[0] : 8'h00;
        b8.req_data[23:16] = (q2.size() > 0) ? q2[0] : 8'h00;
    endtask

    // One clock of the dut8 environment: sample after the edge, log writes,
    // then let each granted producer advance to its next byte.
    task automatic step8();
        @(posedge sample_Clk);
        #1;
        cyc++;
        if (b8.wr_Sig) begin
            wlog.push_back(b8.test_Data);
            wcyc.push_back(cyc);
            chk("grant_with_wr", 32'(b8.grant), 32'(3'b001 << b8.owner));
        end else if (b8.grant != 3'b000) begin
            chk("grant_without_wr", 32'(b8.grant), 32'd0);
        end
        if (b8.grant[0] && q0.size() > 0) void'(q0.pop_front());
        if (b8.grant[1] && q1.size() > 0) void'(q1.pop_front());
        if (b8.grant[2] && q2.size() > 0) void'(q2.pop_front());
        upd8();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        wlog.delete(); wcyc.delete();
        cyc = 0;
        b8.arb_en = 1'b1; b8.buf_full = 1'b0;
        upd8();
        b1.arb_en = 1'b1; b1.buf_full = 1'b0; b1.req = 3'b000;
        b1.req_data = {8'hC0, 8'hB0, 8'hA0};
        repeat (2) @(posedge sample_Clk);
        @(negedge sample_Clk);
        reset = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"},    32'(b8.wr_Sig),    32'd0);
        chk({tag, "_data"},  32'(b8.test_Data), 32'd0);
        chk({tag, "_grant"}, 32'(b8.grant),     32'd0);
        chk({tag, "_owner"}, 32'(b8.owner),     32'd0);
        chk({tag, "_busy"},  32'(b8.busy),      32'd0);
        chk({tag, "_sent"},  32'(b8.sent_cnt),  32'd0);
    endtask

    initial begin
        // ---------------- reset then idle ----------------
        do_reset();
        chk_zero("reset");
        for (int i = 0; i < 20; i++) step8();
        chk("idle_writes", 32'(wlog.size()), 32'd0);
        chk("idle_busy",   32'(b8.busy),     32'd0);
        chk("idle_sent",   32'(b8.sent_cnt), 32'd0);

        // ---------------- single requester, 10 bytes, BURST_LEN=8 ----------------
        do_reset();
        for (int i = 0; i < 10; i++) q0.push_back(8'h11 + 8'(i));
        upd8();
        for (int i = 0; i < 80 && !(wlog.size() == 10 && !b8.busy); i++) step8();
        chk("burst_count", 32'(wlog.size()), 32'd10);
        if (wcyc.size() > 0) chk("burst_first_latency", 32'(wcyc[0]), 32'd1);
        for (int i = 0; i < wlog.size(); i++) chk("burst_data", 32'(wlog[i]), 32'(8'h11 + 8'(i)));
        for (int i = 1; i < wcyc.size(); i++)
            chk("burst_gap", 32'(wcyc[i] - wcyc[i-1]), (i == 8) ? 32'd3 : 32'd2);
        chk("burst_sent", 32'(b8.sent_cnt), 32'd10);

        // ---------------- backpressure in CHECK ----------------
        do_reset();
        q0.push_back(8'h21); q0.push_back(8'h22); q0.push_back(8'h23);
        upd8();
        step8();
        chk("bp_first_write", 32'(wlog.size()), 32'd1);
        b8.buf_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step8();
            chk("bp_owner", 32'(b8.owner), 32'd0);
            chk("bp_busy",  32'(b8.busy),  32'd1);
        end
        chk("bp_no_write", 32'(wlog.size()), 32'd1);
        b8.buf_full = 1'b0;
        step8();
        chk("bp_resume_wr",   32'(b8.wr_Sig),    32'd1);
        chk("bp_resume_data", 32'(b8.test_Data), 32'h22);

        // ---------------- enable drop after 3 bytes ----------------
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back(8'h31 + 8'(i));
        q1.push_back(8'h41);
        upd8();
        for (int i = 0; i < 5; i++) step8();
        chk("en_three_writes", 32'(wlog.size()), 32'd3);
        b8.arb_en = 1'b0;
        step8();
        step8();
        chk("en_busy_fall", 32'(b8.busy), 32'd0);
        step8();
        step8();
        chk("en_no_fourth", 32'(wlog.size()), 32'd3);
        b8.arb_en = 1'b1;
        for (int i = 0; i < 6 && wlog.size() < 4; i++) step8();
        chk("en_next_count", 32'(wlog.size()), 32'd4);
        if (wlog.size() > 3) chk("en_next_req1", 32'(wlog[3]), 32'h41);

        // ---------------- async reset mid-burst ----------------
        do_reset();
        q1.push_back(8'h61);
        upd8();
        step8();
        step8();
        step8();
        q1.push_back(8'h62);
        upd8();
        step8();
        chk("ar_pre_wr",    32'(b8.wr_Sig),    32'd1);
        chk("ar_pre_data",  32'(b8.test_Data), 32'h62);
        chk("ar_pre_owner", 32'(b8.owner),     32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        q0.delete(); q1.delete(); q2.delete();
        q0.push_back(8'h51); q1.push_back(8'h63); q2.push_back(8'h71);
        upd8();
        @(negedge sample_Clk);
        reset = 1'b1;
        step8();
        chk("ar_after_wr",    32'(b8.wr_Sig),    32'd1);
        chk("ar_after_data",  32'(b8.test_Data), 32'h51);
        chk("ar_after_owner", 32'(b8.owner),     32'd0);

        // ---------------- table: BURST_LEN=1 round robin on dut1 ----------------
        tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 3'b111, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 3'b111, 1'b0, 1'b1, 8'hA0, 3'b001, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 3'b111, 1'b0, 1'b1, 8'hB0, 3'b010, 2'd1, 1'b1};
        tbl[7]  = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b0};
        tbl[9]  = '{1'b1, 3'b111, 1'b0, 1'b1, 8'hC0, 3'b100, 2'd2, 1'b1};
        tbl[10] = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b1};
        tbl[11] = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b0};
        tbl[12] = '{1'b1, 3'b111, 1'b0, 1'b1, 8'hA0, 3'b001, 2'd0, 1'b1};
        tbl[13] = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1};
        tbl[14] = '{1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0};
        tbl[15] = '{1'b1, 3'b110, 1'b0, 1'b1, 8'hB0, 3'b010, 2'd1, 1'b1};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            b1.arb_en   = tbl[i].en;
            b1.req      = tbl[i].req;
            b1.buf_full = tbl[i].bf;
            @(posedge sample_Clk);
            #1;
            chk($sformatf("rr%0d_wr", i),    32'(b1.wr_Sig), 32'(tbl[i].exp_wr));
            chk($sformatf("rr%0d_grant", i), 32'(b1.grant),  32'(tbl[i].exp_grant));
            chk($sformatf("rr%0d_owner", i), 32'(b1.owner),  32'(tbl[i].exp_owner));
            chk($sformatf("rr%0d_busy", i),  32'(b1.busy),   32'(tbl[i].exp_busy));
            if (tbl[i].exp_wr)
                chk($sformatf("rr%0d_data", i), 32'(b1.test_Data), 32'(tbl[i].exp_data));
        end
        chk("rr_sent", 32'(b1.sent_cnt), 32'd5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing the UART transmit buffer write port (wr_Sig/test_Data) among NUM_REQ byte producers, e.g. RNG output, RX echo and button-triggered test pattern.
- Grants one requester a burst of up to BURST_LEN bytes, honours buffer backpressure, then rotates priority.
- Sits between the producers and the buffer inside uart_Top, clocked by the bit-rate sample_Clk.

Parameters:
- NUM_REQ, 3, number of requesters, legal range 2..4.
- DATA_W, 8, byte width.
- BURST_LEN, 8, maximum bytes per grant before forced rotation, legal range 1..255.

Ports:
- sample_Clk  input  1  clock (bit-rate sample clock).
- reset  input  1  asynchronous, active-low reset.
- arb_en  input  1  scheduler enable; 0 = no new writes.
- req  input  NUM_REQ  per-requester byte-valid level.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester k uses bits [k*DATA_W +: DATA_W].
- buf_full  input  1  transmit buffer cannot accept a write.
- grant  output  NUM_REQ  one-cycle ack; byte of that requester was written.
- wr_Sig  output  1  buffer write strobe, one cycle.
- test_Data  output  DATA_W  byte to buffer, valid when wr_Sig=1.
- owner  output  2  index of current burst owner.
- busy  output  1  1 while a burst is owned (state != IDLE).
- sent_cnt  output  16  total bytes written; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, reset=0) values:
  - State IDLE.
  - wr_Sig=0, test_Data=0, grant=0, owner=0, busy=0, sent_cnt=0.
  - Priority pointer ptr=0; burst counter cnt=0.
- All outputs are registered. wr_Sig and the grant bit assert in the same cycle.
- Requester contract:
  - Hold req and data stable until the grant is seen.
  - On the edge ending the grant cycle, present the next byte or drop req.
- States:
  - IDLE: requires arb_en=1, |req=1 and buf_full=0. Then:
    - Select the first k with req[k]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
    - owner<=k, wr_Sig<=1, test_Data<=req_data[k], grant[k]<=1, cnt<=1, sent_cnt++, go ACK.
    - Otherwise stay in IDLE with ptr unchanged.
  - ACK: wr_Sig<=0, grant<=0, go CHECK. No sampling of req here, because the requester is updating this cycle.
  - CHECK, evaluated in priority order:
    1. If arb_en=0, or req[owner]=0, or cnt==BURST_LEN: release. ptr<=owner+1 (wrap NUM_REQ-1 -> 0), cnt<=0, go IDLE. No write.
    2. Else if buf_full=1: stay in CHECK holding ownership, no write.
    3. Else: write req_data[owner], grant[owner] pulse, cnt++, sent_cnt++, go ACK.
- Throughput:
  - Maximum one byte per 2 cycles within a burst.
  - Release costs 1 cycle in CHECK and 1 cycle in IDLE before the next grant.
- Write latency: first write appears on the edge after the IDLE-cycle conditions are met (1 cycle).
- Boundary conditions:
  - Simultaneous requests: only the ptr-ordered winner is served; others wait for rotation.
  - BURST_LEN=1: every grant releases after one byte, giving strict round-robin per byte.
  - buf_full asserted in the same cycle as a candidate write: no write, no grant, no count change.
  - req of a non-owner dropping mid-burst: no effect.
  - arb_en falling mid-burst: the current ACK completes, then release in CHECK. A byte already written is never retracted.
  - Reset mid-burst: immediate clear. The grant was never issued for an unwritten byte, so no data is lost or duplicated.
  - sent_cnt wraps silently.

Decomposition:
- Package uart_sched_pkg holds:
  - State encodings: IDLE=2'd0, ACK=2'd1, CHECK=2'd2.
  - DATA_W default.
  - Counter width 16.
- Sub-module rr_pick: combinational. Inputs req and ptr; outputs found and idx (first set bit at or after ptr, wrapping).
- The FSM, counters and output registers stay in uart_tx_sched.

Test Plan:
- Reset then idle: req=0, arb_en=1 for 20 cycles.
  - Required: wr_Sig never 1, busy=0, sent_cnt=0.
- Single requester burst: req[0]=1 for 10 bytes 0x11..0x1A, BURST_LEN=8.
  - Required: 8 writes 0x11..0x18, one every 2 cycles.
  - Release, IDLE, then re-grant to req0: remaining 0x19, 0x1A follow.
  - sent_cnt=10.
- Round-robin: req0, req1, req2 all high continuously with data 0xA0/0xB0/0xC0, BURST_LEN=1.
  - Required: write order 0xA0, 0xB0, 0xC0, 0xA0...
  - grant pulses coincide with wr_Sig.
- Backpressure: buf_full=1 for 5 cycles while in CHECK with req0 high.
  - Required: no wr_Sig, owner held at 0.
  - Write resumes the cycle after buf_full=0 is sampled.
- Enable drop: arb_en=0 during a burst after 3 bytes.
  - Required: no 4th write; busy falls within 2 cycles; ptr=1.
  - With req0 and req1 high and arb_en restored, next grant goes to req1.
- Async reset mid-burst: reset=0 between edges during ACK.
  - Required: all outputs 0 immediately.
  - After release, first grant goes to lowest requesting index from ptr=0.
